// File: rtl/sha512_block_loader_if.sv
// Stream interface for the SHA-512 message loader.
// Ingress side: 64-bit little-endian words with a valid/ready/last handshake.
// Egress side: 1024-bit message blocks with first/last tags and a valid/ready handshake.
// The master modport is the surrounding environment (DMA side plus compression core);
// the slave modport is the loader itself.
interface sha512_block_loader_if;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [1023:0] m_block;
  logic          m_first;
  logic          m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_block, m_first, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_block, m_first, m_last
  );
endinterface

// File: rtl/sha512_block_loader.sv
// SHA-512 message block loader.
// Accepts little-endian 64-bit words, byte-reverses each one and packs 16 of
// them into a 1024-bit big-endian block (W0 in the top 64 bits), then hands the
// block to the compression core tagged with first/last-of-message flags.
// A message ending before word 15 closes a zero-filled block and sets the
// sticky err_short flag; padding is left to software.
// Optional build macro: SHA512_LOADER_DBUF_EN selects a two-bank ping-pong
// buffer so one bank fills while the other waits for the core. Without it a
// single bank is used and input stalls for the whole time a block is held.
module sha512_block_loader #(
  parameter int WORDS = 16,
  parameter int DW    = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  sha512_block_loader_if.slave  bus,
  input  logic                  clr_err,
  output logic                  err_short,
  output logic [3:0]            word_cnt
);

  localparam int BW = WORDS * DW;

`ifdef SHA512_LOADER_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } bank_state_t;

  // Per-bank state; in the single-bank build bank 1 never leaves FILL and
  // both pointers stay at 0.
  bank_state_t       state_r   [2];
  bank_state_t       state_nxt [2];
  logic              wr_sel_r;
  logic              wr_sel_nxt;
  logic              rd_sel_r;
  logic              rd_sel_nxt;

  logic [BW-1:0]     bank_r [2];
  logic [1:0]        first_r;
  logic [1:0]        last_r;
  logic              armed_r;
  logic [3:0]        word_cnt_r;
  logic              err_short_r;

  logic              s_ready_s;
  logic              m_valid_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              close_s;
  logic              short_s;
  logic [9:0]        slot_top_s;

  // Byte reversal of one word: byte 0 of the input lands in the top byte.
  function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW / 8; i++) begin
      r[DW-1-8*i -: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  assign s_ready_s  = (state_r[wr_sel_r] == FILL);
  assign m_valid_s  = (state_r[rd_sel_r] == HOLD);
  assign in_xfer_s  = bus.s_valid & s_ready_s;
  assign out_xfer_s = m_valid_s & bus.m_ready;
  assign close_s    = in_xfer_s & ((word_cnt_r == 4'(WORDS - 1)) | bus.s_last);
  assign short_s    = in_xfer_s & bus.s_last & (word_cnt_r != 4'(WORDS - 1));
  // Slot k occupies bits [BW-1-64k -: 64]; word_cnt*64 is a shift by 6.
  assign slot_top_s = 10'(BW - 1) - {word_cnt_r, 6'd0};

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = m_valid_s;
  assign bus.m_block = bank_r[rd_sel_r];
  assign bus.m_first = first_r[rd_sel_r];
  assign bus.m_last  = last_r[rd_sel_r];
  assign err_short   = err_short_r;
  assign word_cnt    = word_cnt_r;

  // Bank state and bank pointer registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r[0] <= FILL;
      state_r[1] <= FILL;
      wr_sel_r   <= 1'b0;
      rd_sel_r   <= 1'b0;
    end else begin
      state_r[0] <= state_nxt[0];
      state_r[1] <= state_nxt[1];
      wr_sel_r   <= wr_sel_nxt;
      rd_sel_r   <= rd_sel_nxt;
    end
  end

  // Next-state: a closing word moves the fill bank to HOLD, an accepted block
  // returns the output bank to FILL. The two never target the same bank.
  always_comb begin
    state_nxt[0] = state_r[0];
    state_nxt[1] = state_r[1];
    wr_sel_nxt   = wr_sel_r;
    rd_sel_nxt   = rd_sel_r;
    if (close_s) begin
      state_nxt[wr_sel_r] = HOLD;
      wr_sel_nxt          = DBUF ? ~wr_sel_r : 1'b0;
    end else begin
      wr_sel_nxt = wr_sel_r;
    end
    if (out_xfer_s) begin
      state_nxt[rd_sel_r] = FILL;
      rd_sel_nxt          = DBUF ? ~rd_sel_r : 1'b0;
    end else begin
      rd_sel_nxt = rd_sel_r;
    end
  end

  // Block datapath: slot writes, block tags, word counter and armed flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bank_r[0]  <= '0;
      bank_r[1]  <= '0;
      first_r    <= 2'b00;
      last_r     <= 2'b00;
      armed_r    <= 1'b1;
      word_cnt_r <= 4'd0;
    end else begin
      if (in_xfer_s) begin
        bank_r[wr_sel_r][slot_top_s -: DW] <= byte_swap(bus.s_data);
        if (close_s) begin
          word_cnt_r        <= 4'd0;
          first_r[wr_sel_r] <= armed_r;
          last_r[wr_sel_r]  <= bus.s_last;
          armed_r           <= bus.s_last;
        end else begin
          word_cnt_r <= word_cnt_r + 4'd1;
        end
      end
      if (out_xfer_s) begin
        bank_r[rd_sel_r]  <= '0;
        first_r[rd_sel_r] <= 1'b0;
        last_r[rd_sel_r]  <= 1'b0;
      end
    end
  end

  // Sticky short-message flag; a clear request wins over a simultaneous set.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_short_r <= 1'b0;
    end else if (clr_err) begin
      err_short_r <= 1'b0;
    end else if (short_s) begin
      err_short_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha512_block_loader.sv
// Directed self-checking bench for sha512_block_loader.
module tb_sha512_block_loader;

  logic       clk;
  logic       aresetn;
  logic       clr_err;
  logic       err_short;
  logic [3:0] word_cnt;
  int         errors;
  int         checks;

  sha512_block_loader_if bus ();

  sha512_block_loader dut (
    .aclk      (clk),
    .aresetn   (aresetn),
    .bus       (bus),
    .clr_err   (clr_err),
    .err_short (err_short),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte b of input word k; k>=32 gets an extra xor so later words stay distinct.
  function automatic logic [7:0] pat_byte(input int k, input int b);
    return 8'(8 * k + b) ^ 8'((k / 32) * 165);
  endfunction

  function automatic logic [63:0] dle(input int k);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = pat_byte(k, b);
    return r;
  endfunction

  function automatic logic [63:0] wbe(input int k);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[63-8*b -: 8] = pat_byte(k, b);
    return r;
  endfunction

  function automatic logic [1023:0] exp_blk(input int base, input int n);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[1023-64*i -: 64] = wbe(base + i);
    end
    return r;
  endfunction

  // Offer one word at a negedge and return at the negedge after it is taken.
  task automatic push(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL push_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, n);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic push_run(input int base, input int n, input logic last);
    for (int i = 0; i < n; i++) push(dle(base + i), last && (i == n - 1));
  endtask

  task automatic test_reset;
    aresetn     = 1'b0;
    clr_err     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 64'd0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.m_valid, bus.m_first, bus.m_last, err_short, word_cnt} !== {5'b10000, 4'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b fst=%b lst=%b err=%b cnt=%0d required 1 0 0 0 0 0",
               bus.s_ready, bus.m_valid, bus.m_first, bus.m_last, err_short, word_cnt);
    end
    checks++;
    if (bus.m_block !== 1024'd0) begin
      errors++;
      $display("FAIL reset_block: got %h required 0", bus.m_block);
    end
  endtask

  task automatic test_full_block;
    bus.m_ready = 1'b1;
    push_run(0, 16, 1'b1);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL t1_m_valid: got %b required 1", bus.m_valid);
    end
    checks++;
    if (bus.m_block[1023:960] !== 64'h0001020304050607) begin
      errors++;
      $display("FAIL t1_w0: got %h required 0001020304050607", bus.m_block[1023:960]);
    end
    checks++;
    if (bus.m_block !== exp_blk(0, 16)) begin
      errors++;
      $display("FAIL t1_block: got %h required %h", bus.m_block, exp_blk(0, 16));
    end
    checks++;
    if ({bus.m_first, bus.m_last, err_short} !== 3'b110) begin
      errors++;
      $display("FAIL t1_tags: got fst=%b lst=%b err=%b required 1 1 0", bus.m_first, bus.m_last, err_short);
    end
    @(negedge clk);
    checks++;
    if ({bus.m_valid, bus.s_ready, word_cnt} !== {2'b01, 4'd0}) begin
      errors++;
      $display("FAIL t1_after: got vld=%b rdy=%b cnt=%0d required 0 1 0", bus.m_valid, bus.s_ready, word_cnt);
    end
  endtask

  task automatic test_two_blocks;
    push_run(0, 16, 1'b0);
    checks++;
    if ({bus.m_valid, bus.m_first, bus.m_last} !== 3'b110) begin
      errors++;
      $display("FAIL t2_blk1_tags: got vld=%b fst=%b lst=%b required 1 1 0", bus.m_valid, bus.m_first, bus.m_last);
    end
    push_run(16, 16, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_first, bus.m_last} !== 3'b101) begin
      errors++;
      $display("FAIL t2_blk2_tags: got vld=%b fst=%b lst=%b required 1 0 1", bus.m_valid, bus.m_first, bus.m_last);
    end
    checks++;
    if (bus.m_block !== exp_blk(16, 16)) begin
      errors++;
      $display("FAIL t2_blk2_data: got %h required %h", bus.m_block, exp_blk(16, 16));
    end
    @(negedge clk);
  endtask

  task automatic test_short;
    push_run(0, 5, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_first, bus.m_last, err_short} !== 4'b1111) begin
      errors++;
      $display("FAIL t3_flags: got vld=%b fst=%b lst=%b err=%b required 1 1 1 1",
               bus.m_valid, bus.m_first, bus.m_last, err_short);
    end
    checks++;
    if (bus.m_block[703:0] !== 704'd0) begin
      errors++;
      $display("FAIL t3_zero_fill: got %h required 0", bus.m_block[703:0]);
    end
    checks++;
    if (bus.m_block !== exp_blk(0, 5)) begin
      errors++;
      $display("FAIL t3_block: got %h required %h", bus.m_block, exp_blk(0, 5));
    end
    @(negedge clk);
    checks++;
    if (err_short !== 1'b1) begin
      errors++;
      $display("FAIL t3_sticky: got %b required 1", err_short);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (err_short !== 1'b0) begin
      errors++;
      $display("FAIL t3_clear: got %b required 0", err_short);
    end
  endtask

  task automatic test_backpressure;
    logic [1023:0] held;
    bus.m_ready = 1'b0;
    push_run(32, 16, 1'b1);
    held = exp_blk(32, 16);
`ifdef SHA512_LOADER_DBUF_EN
    bus.s_valid = 1'b0;
`else
    bus.s_valid = 1'b1;
    bus.s_data  = dle(7);
`endif
    for (int c = 0; c < 10; c++) begin
      checks++;
`ifdef SHA512_LOADER_DBUF_EN
      if ({bus.m_valid, bus.s_ready} !== 2'b11) begin
        errors++;
        $display("FAIL t4_hold_c%0d: got vld=%b rdy=%b required 1 1", c, bus.m_valid, bus.s_ready);
      end
`else
      if ({bus.m_valid, bus.s_ready} !== 2'b10) begin
        errors++;
        $display("FAIL t4_hold_c%0d: got vld=%b rdy=%b required 1 0", c, bus.m_valid, bus.s_ready);
      end
`endif
      checks++;
      if (bus.m_block !== held) begin
        errors++;
        $display("FAIL t4_stable_c%0d: got %h required %h", c, bus.m_block, held);
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.m_valid, bus.s_ready, word_cnt} !== {2'b01, 4'd0}) begin
      errors++;
      $display("FAIL t4_release: got vld=%b rdy=%b cnt=%0d required 0 1 0", bus.m_valid, bus.s_ready, word_cnt);
    end
  endtask

  task automatic test_async_reset;
    push_run(0, 3, 1'b1);
    @(negedge clk);
    push_run(0, 16, 1'b0);
    @(negedge clk);
    push_run(0, 7, 1'b0);
    checks++;
    if ({word_cnt, err_short} !== {4'd7, 1'b1}) begin
      errors++;
      $display("FAIL t5_pre: got cnt=%0d err=%b required 7 1", word_cnt, err_short);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.m_valid, bus.m_first, bus.m_last, err_short, word_cnt} !== {5'b10000, 4'd0}) begin
      errors++;
      $display("FAIL t5_in_reset: got rdy=%b vld=%b fst=%b lst=%b err=%b cnt=%0d required 1 0 0 0 0 0",
               bus.s_ready, bus.m_valid, bus.m_first, bus.m_last, err_short, word_cnt);
    end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    push_run(40, 16, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_first, bus.m_last} !== 3'b111) begin
      errors++;
      $display("FAIL t5_tags: got vld=%b fst=%b lst=%b required 1 1 1", bus.m_valid, bus.m_first, bus.m_last);
    end
    checks++;
    if (bus.m_block !== exp_blk(40, 16)) begin
      errors++;
      $display("FAIL t5_block: got %h required %h", bus.m_block, exp_blk(40, 16));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int nb;
    int drops;
    int cyc;
    logic pushing;
    nb      = 0;
    drops   = 0;
    cyc     = 0;
    pushing = 1'b1;
    bus.m_ready = 1'b1;
    fork
      begin
        push_run(0, 64, 1'b1);
        pushing = 1'b0;
      end
      begin
        while (nb < 4 && cyc < 400) begin
          #1;
          if (pushing && !bus.s_ready) drops++;
          if (bus.m_valid) begin
            checks++;
            if (bus.m_block !== exp_blk(16 * nb, 16)) begin
              errors++;
              $display("FAIL t6_block%0d: got %h required %h", nb, bus.m_block, exp_blk(16 * nb, 16));
            end
            checks++;
            if ({bus.m_first, bus.m_last} !== {nb == 0, nb == 3}) begin
              errors++;
              $display("FAIL t6_tags%0d: got fst=%b lst=%b required %b %b",
                       nb, bus.m_first, bus.m_last, nb == 0, nb == 3);
            end
            nb++;
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    checks++;
    if (nb != 4) begin
      errors++;
      $display("FAIL t6_count: got %0d blocks required 4", nb);
    end
`ifdef SHA512_LOADER_DBUF_EN
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL t6_ready_drop: got %0d stalled cycles required 0", drops);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_full_block();
    test_two_blocks();
    test_short();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
